// File: rtl/req_hold_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | req_hold_fifo: assembles two-cycle calc1 requests into a FIFO queue   |
// | Optional drop counter: define REQ_HOLD_OVF_CNT_EN                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module req_hold_fifo #(
  parameter int CMD_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       c_clk,
  input  logic                       reset,
  input  logic [CMD_W-1:0]           req_cmd_in,
  input  logic [DATA_W-1:0]          req_data_in,
  input  logic                       hold_ready,
  output logic                       hold_valid,
  output logic [CMD_W-1:0]           hold_cmd,
  output logic [DATA_W-1:0]          hold_data1,
  output logic [DATA_W-1:0]          hold_data2,
  output logic [$clog2(DEPTH+1)-1:0] hold_count,
  output logic                       hold_full,
  output logic                       hold_ovf
`ifdef REQ_HOLD_OVF_CNT_EN
  ,
  output logic [7:0]                 hold_ovf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OP2  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CMD_W-1:0]    r_cmd;
  logic [DATA_W-1:0]   r_data1;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  logic [CMD_W-1:0]    r_mem_cmd   [DEPTH];
  logic [DATA_W-1:0]   r_mem_data1 [DEPTH];
  logic [DATA_W-1:0]   r_mem_data2 [DEPTH];

  logic                w_pop;
  logic                w_push_try;
  logic                w_push;
  logic                w_drop;

  assign hold_valid = (r_count != '0);
  assign hold_full  = (r_count == CNT_W'(DEPTH));
  assign hold_count = r_count;
  assign hold_ovf   = r_ovf;

  assign w_pop      = hold_valid && hold_ready;
  assign w_push_try = (r_state == S_OP2);
  // A full queue still accepts when the head leaves on the same edge.
  assign w_push     = w_push_try && (!hold_full || w_pop);
  assign w_drop     = w_push_try && !w_push;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_cmd_in != '0) w_state_nxt = S_OP2;
      S_OP2:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      r_cmd   <= '0;
      r_data1 <= '0;
    end else if (r_state == S_IDLE && req_cmd_in != '0) begin
      r_cmd   <= req_cmd_in;
      r_data1 <= req_data_in;
    end
  end

  // Storage needs no reset: outputs are gated by hold_valid.
  always_ff @(negedge c_clk) begin
    if (!reset && w_push) begin
      r_mem_cmd[r_wr_ptr]   <= r_cmd;
      r_mem_data1[r_wr_ptr] <= r_data1;
      r_mem_data2[r_wr_ptr] <= req_data_in;
    end
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    hold_cmd   = '0;
    hold_data1 = '0;
    hold_data2 = '0;
    if (hold_valid) begin
      hold_cmd   = r_mem_cmd[r_rd_ptr];
      hold_data1 = r_mem_data1[r_rd_ptr];
      hold_data2 = r_mem_data2[r_rd_ptr];
    end
  end

`ifdef REQ_HOLD_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(negedge c_clk) begin
    if (reset) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_drop && r_ovf_cnt != 8'hFF) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign hold_ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire
